// File: rtl/data_ram_sync_pkg.sv
// Data-interface constants shared by the core's load/store unit and the data memories.
package data_ram_sync_pkg;

  localparam int DATA_W        = 32;
  localparam int BE_W          = DATA_W / 8;
  localparam int DEFAULT_DEPTH = 4096;

  // Byte-enable encodings as driven by the core for byte, halfword and word accesses
  localparam logic [BE_W-1:0] BE_BYTE0   = 4'b0001;
  localparam logic [BE_W-1:0] BE_BYTE1   = 4'b0010;
  localparam logic [BE_W-1:0] BE_BYTE2   = 4'b0100;
  localparam logic [BE_W-1:0] BE_BYTE3   = 4'b1000;
  localparam logic [BE_W-1:0] BE_HALF_LO = 4'b0011;
  localparam logic [BE_W-1:0] BE_HALF_HI = 4'b1100;
  localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/data_ram_sync_ram_byte_lane.sv
// One 8-bit wide byte lane of the data memory: synchronous write, combinational read.
module ram_byte_lane #(
  parameter int DEPTH = 4096,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [7:0]       wdata_i,
  output logic [7:0]       rdata_o
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[idx_i];

endmodule

// File: rtl/data_ram_sync.sv
// Single-port byte-writable data memory with a fixed one-cycle registered response.
module data_ram_sync #(
  parameter int DEPTH  = data_ram_sync_pkg::DEFAULT_DEPTH,
  parameter int ADDR_W = 32,
  parameter int DATA_W = data_ram_sync_pkg::DATA_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ce_i,
  input  logic                  wr_en_i,
  input  logic [DATA_W/8-1:0]   sel_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  data_rvalid_o,
  output logic                  write_success_o
);

  import data_ram_sync_pkg::*;

  localparam int IDX_W     = $clog2(DEPTH);
  localparam int NUM_LANES = DATA_W / 8;

  logic [IDX_W-1:0]  word_idx;
  logic [DATA_W-1:0] word_rdata;
  logic              wr_req;
  logic              rd_req;
  logic              unused_addr;

  // Byte offset and bits above the array size are dropped, so addresses wrap
  assign word_idx    = addr_i[IDX_W+1:2];
  assign unused_addr = ^{addr_i[ADDR_W-1:IDX_W+2], addr_i[1:0]};

  // Requests seen while reset is asserted must not touch the array
  assign wr_req = rst_ni & ce_i & wr_en_i;
  assign rd_req = rst_ni & ce_i & ~wr_en_i;

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    ram_byte_lane #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
    ) u_lane (
      .clk_i   (clk_i),
      .we_i    (wr_req & sel_i[n]),
      .idx_i   (word_idx),
      .wdata_i (wdata_i[8*n +: 8]),
      .rdata_o (word_rdata[8*n +: 8])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_o         <= '0;
      data_rvalid_o   <= 1'b0;
      write_success_o <= 1'b0;
    end else begin
      data_rvalid_o   <= ce_i;
      write_success_o <= wr_req;
      if (rd_req) begin
        rdata_o <= word_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_ram_sync.sv
// Self-checking bench for data_ram_sync: directed scenarios plus randomized traffic vs. a word-array model.
module tb_data_ram_sync;

  localparam int DEPTH = 4096;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ce_i;
  logic        wr_en_i;
  logic [3:0]  sel_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        data_rvalid_o;
  logic        write_success_o;

  int testsRun = 0;
  int testsFailed = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] expRdata = 32'h0;
  logic        expRvalid = 1'b0;
  logic        expWsucc = 1'b0;

  data_ram_sync #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .ce_i            (ce_i),
    .wr_en_i         (wr_en_i),
    .sel_i           (sel_i),
    .addr_i          (addr_i),
    .wdata_i         (wdata_i),
    .rdata_o         (rdata_o),
    .data_rvalid_o   (data_rvalid_o),
    .write_success_o (write_success_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // One clock of traffic: drive, let the model react at the edge, then compare just after it
  task automatic applyStimulus(input bit rst, input bit ce, input bit we,
                               input logic [3:0] sel, input logic [31:0] addr,
                               input logic [31:0] wdata, input string tag);
    int idx;
    rst_ni  = rst;
    ce_i    = ce;
    wr_en_i = we;
    sel_i   = sel;
    addr_i  = addr;
    wdata_i = wdata;
    idx = int'((addr / 4) % DEPTH);
    @(posedge clk_i);
    if (!rst) begin
      expRdata  = 32'h0;
      expRvalid = 1'b0;
      expWsucc  = 1'b0;
    end else if (ce && we) begin
      for (int n = 0; n < 4; n++)
        if (sel[n]) model[idx][8*n +: 8] = wdata[8*n +: 8];
      expRvalid = 1'b1;
      expWsucc  = 1'b1;
    end else if (ce) begin
      expRdata  = model[idx];
      expRvalid = 1'b1;
      expWsucc  = 1'b0;
    end else begin
      expRvalid = 1'b0;
      expWsucc  = 1'b0;
    end
    #1;
    checkOutput({tag, ".rvalid"}, {31'b0, data_rvalid_o}, {31'b0, expRvalid});
    checkOutput({tag, ".wsucc"}, {31'b0, write_success_o}, {31'b0, expWsucc});
    checkOutput({tag, ".rdata"}, rdata_o, expRdata);
  endtask

  initial begin
    logic [31:0] addr;
    logic [3:0]  sel;

    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, "init_rst");
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, "init_rst");
    applyStimulus(1, 1, 1, 4'hF, 32'h0, 32'hA5A5_0F0F, "preload0");

    for (int i = 0; i < 10; i++)
      applyStimulus(0, 1, 1, 4'hF, 32'h0, 32'hDEAD_BEEF, "reset_hold");
    applyStimulus(1, 1, 0, 4'h0, 32'h0, 32'h0, "read_after_reset");
    checkOutput("no_write_in_reset", rdata_o, 32'hA5A5_0F0F);

    applyStimulus(1, 1, 1, 4'hF, 32'h10, 32'h1234_5678, "word_write");
    applyStimulus(1, 1, 0, 4'hF, 32'h10, 32'h0, "word_read");
    checkOutput("word_read_value", rdata_o, 32'h1234_5678);

    applyStimulus(1, 1, 1, 4'hF, 32'h20, 32'h0, "clear20");
    applyStimulus(1, 1, 1, 4'b0010, 32'h20, 32'h0000_AB00, "byte1_write");
    applyStimulus(1, 1, 1, 4'b1100, 32'h20, 32'hCDEF_0000, "half_hi_write");
    applyStimulus(1, 1, 0, 4'h0, 32'h20, 32'h0, "merged_read");
    checkOutput("merged_value", rdata_o, 32'hCDEF_AB00);
    applyStimulus(1, 1, 1, 4'b0000, 32'h20, 32'hFFFF_FFFF, "sel0_write");
    applyStimulus(1, 1, 0, 4'h0, 32'h20, 32'h0, "sel0_read");
    checkOutput("sel0_unchanged", rdata_o, 32'hCDEF_AB00);

    applyStimulus(1, 1, 1, 4'hF, 32'h4000, 32'h55AA_55AA, "wrap_write");
    applyStimulus(1, 1, 0, 4'h0, 32'h0000, 32'h0, "wrap_read0");
    checkOutput("wrap_value", rdata_o, 32'h55AA_55AA);
    applyStimulus(1, 1, 0, 4'h0, 32'h0003, 32'h0, "unaligned_read");

    applyStimulus(1, 1, 0, 4'h0, 32'h10, 32'h0, "b2b_0");
    applyStimulus(1, 1, 0, 4'h0, 32'h20, 32'h0, "b2b_1");
    applyStimulus(1, 1, 0, 4'h0, 32'h10, 32'h0, "b2b_2");
    applyStimulus(1, 0, 0, 4'h0, 32'h0, 32'h0, "idle_hold");

    applyStimulus(1, 1, 0, 4'h0, 32'h20, 32'h0, "mid_read");
    applyStimulus(0, 1, 0, 4'h0, 32'h10, 32'h0, "mid_rst");
    applyStimulus(1, 0, 0, 4'h0, 32'h0, 32'h0, "post_rst");
    applyStimulus(1, 0, 0, 4'h0, 32'h0, 32'h0, "post_rst2");

    // Give every word in the random window a known value before random traffic
    for (int w = 0; w < 16; w++)
      applyStimulus(1, 1, 1, 4'hF, 32'(w * 4), $urandom, "fill");

    for (int i = 0; i < 400; i++) begin
      addr = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
      sel  = 4'($urandom);
      applyStimulus(($urandom_range(0, 99) >= 3), ($urandom_range(0, 3) != 0), 1'($urandom),
                    sel, addr, $urandom, "random");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
